// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module : icache_pkg
// Brief  : Shared block geometry and fill-state encoding for the I-cache
//          miss-handling controller.
// Rev    : 1.0  initial release
// ============================================================================
package icache_pkg;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int BLOCK_OFFSET_W  = 4;
    localparam int WORD_SEL_W      = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/fill_counter.sv
`default_nettype none
// ============================================================================
// Module : fill_counter
// Brief  : Word counter with synchronous clear, enable and a sticky done flag
//          that rises on the enabled step past the last word.
// Rev    : 1.0  initial release
// ============================================================================
module fill_counter
    import icache_pkg::*;
#(
    parameter int WIDTH = WORD_SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;
    logic             r_done;

    // The count parks on the last word once done, so address/select decodes
    // that depend on it keep showing the final word.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (i_en && !r_done) begin
            if (r_count == {WIDTH{1'b1}}) begin
                r_done <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_count = r_count;
    assign o_done  = r_done;

endmodule
`default_nettype wire

// File: rtl/icache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module : icache_fill_fsm
// Brief  : I-cache miss fill controller: requests a whole block from memory,
//          writes each returned word, then pulses the tag write.
//          Optional macro ICACHE_CRITICAL_WORD_FIRST_EN fetches the missed
//          word first and wraps around the block.
// Rev    : 1.0  initial release
// ============================================================================
module icache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = icache_pkg::WORDS_PER_BLOCK,
    parameter int ADDR_W          = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              miss_detected,
    input  logic [ADDR_W-1:0]                 miss_address,
    input  logic                              memory_data_valid,
    input  logic [15:0]                       memory_data,
    output logic                              fsm_busy,
    output logic                              mem_read_req,
    output logic [ADDR_W-1:0]                 memory_address,
    output logic                              write_data_array,
    output logic [icache_pkg::WORD_SEL_W-1:0] array_word_sel,
    output logic [15:0]                       array_data,
    output logic                              write_tag_array,
    output logic                              crit_word_valid
);

    import icache_pkg::*;

    localparam int c_sel_w = $clog2(WORDS_PER_BLOCK);

    fill_state_t        r_state;
    fill_state_t        w_next_state;
    logic [ADDR_W-1:0]  r_base;
    logic [c_sel_w-1:0] r_miss_off;
    logic [c_sel_w-1:0] w_start;
    logic [c_sel_w-1:0] w_issue_cnt;
    logic [c_sel_w-1:0] w_recv_cnt;
    logic [c_sel_w-1:0] w_issue_sel;
    logic [c_sel_w-1:0] w_recv_sel;
    logic               w_issue_done;
    logic               w_recv_done;
    logic               w_miss_accept;
    logic               w_issue;
    logic               w_write;
    logic               w_last;
    logic               w_crit;
    logic               w_unused;

    assign w_unused      = miss_address[0];
    assign w_miss_accept = (r_state == IDLE) && miss_detected;
    assign w_issue       = (r_state == FILL) && !w_issue_done;
    assign w_write       = (r_state == FILL) && memory_data_valid && !w_recv_done;
    assign w_last        = w_write && (w_recv_cnt == {c_sel_w{1'b1}});

    // Word offsets wrap naturally inside the block through c_sel_w-bit adds.
    assign w_issue_sel = w_start + w_issue_cnt;
    assign w_recv_sel  = w_start + w_recv_cnt;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    assign w_start = r_miss_off;
    assign w_crit  = w_write && (w_recv_cnt == '0);
`else
    assign w_start = '0;
    assign w_crit  = w_write && (w_recv_sel == r_miss_off);
`endif

    fill_counter #(.WIDTH(c_sel_w)) u_issue_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_miss_accept),
        .i_en    (w_issue),
        .o_count (w_issue_cnt),
        .o_done  (w_issue_done)
    );

    fill_counter #(.WIDTH(c_sel_w)) u_recv_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_miss_accept),
        .i_en    (w_write),
        .o_count (w_recv_cnt),
        .o_done  (w_recv_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Block base and miss offset are captured only when a fill is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base     <= '0;
            r_miss_off <= '0;
        end else if (w_miss_accept) begin
            r_base     <= {miss_address[ADDR_W-1:BLOCK_OFFSET_W], {BLOCK_OFFSET_W{1'b0}}};
            r_miss_off <= miss_address[BLOCK_OFFSET_W-1:1];
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (miss_detected) w_next_state = FILL;
            FILL:    if (w_last)        w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        fsm_busy         = (r_state == FILL);
        mem_read_req     = w_issue;
        memory_address   = r_base | ADDR_W'({w_issue_sel, 1'b0});
        write_data_array = w_write;
        array_word_sel   = '0;
        if (w_write) begin
            array_word_sel = WORD_SEL_W'(w_recv_sel);
        end
        array_data       = memory_data;
        write_tag_array  = w_last;
        crit_word_valid  = w_crit;
    end

endmodule
`default_nettype wire

// File: doc/icache_fill_fsm.md
Name: icache_fill_fsm

Overview:
- Miss-handling controller between the instruction-fetch stage's cache arrays and multi-cycle main memory.
- On a fetch miss it requests the whole 16-byte block (eight 16-bit words) from memory. It writes each returned word into the cache data array, then writes the tag.
- It holds fsm_busy high while filling, so the pipeline freezes the PC register and the IF/ID register.

Parameters:
- WORDS_PER_BLOCK, 8, number of 16-bit words per cache block; must be a power of two.
- ADDR_W, 16, byte-address width.

Ports:
- clk  in  1  system clock, all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- miss_detected  in  1  fetch-side cache miss this cycle.
- miss_address  in  ADDR_W  byte address of the missing fetch.
- memory_data_valid  in  1  memory returns one word this cycle.
- memory_data  in  16  returned word.
- fsm_busy  out  1  fill in progress; the stall source for the PC and IF/ID registers.
- mem_read_req  out  1  issue a read to memory at memory_address this cycle.
- memory_address  out  ADDR_W  word-aligned request address.
- write_data_array  out  1  write array_data into the data array at array_word_sel.
- array_word_sel  out  3  word offset within the block being written.
- array_data  out  16  word to write; equals memory_data.
- write_tag_array  out  1  one-cycle pulse that writes the tag and valid bit for the latched block.
- crit_word_valid  out  1  requested word is on array_data this cycle (see Optional Feature).

Behaviour:
- Reset: state IDLE, issue_cnt=0, recv_cnt=0, base=0. All outputs 0: fsm_busy, mem_read_req, write_data_array, write_tag_array, crit_word_valid, memory_address, array_word_sel.
- Reset asserted mid-fill: return to IDLE on the next edge with counters cleared. No further array writes; the tag is not written. Late memory_data_valid pulses after reset are ignored.
- States: IDLE, FILL.
- IDLE, miss_detected=1:
  - latch base = miss_address with bits [3:0] cleared;
  - clear both counters;
  - go to FILL.
- IDLE, miss_detected=0: no change.
- memory_data_valid while in IDLE: ignored.
- FILL: fsm_busy=1 (registered state decode). The cache asserts the miss-cycle stall itself.
- Issue side, in FILL:
  - while issue_cnt < WORDS_PER_BLOCK: mem_read_req=1, memory_address = base + 2*issue_cnt, issue_cnt increments each cycle;
  - afterwards mem_read_req=0 and memory_address holds its last value.
- Receive side, in FILL, each memory_data_valid:
  - write_data_array=1, array_word_sel=recv_cnt, array_data=memory_data, then recv_cnt increments;
  - the block makes no assumption about memory latency and counts valids only;
  - a valid may arrive in the same cycle as a request.
- Completion: on the valid carrying word WORDS_PER_BLOCK-1, write_tag_array=1 in that same cycle and the next state is IDLE. fsm_busy is low from the following cycle.
- miss_detected while in FILL: ignored, and no re-latch of base. The same cycle that FILL exits to IDLE counts as FILL, so a miss there is also ignored.
- Excess valid after recv_cnt saturates: impossible in normal operation; ignored, with no write.
- Timing with a 4-cycle memory, miss sampled at cycle 0:
  - requests in cycles 1-8;
  - data valids in cycles 5-12;
  - tag write in cycle 12;
  - fsm_busy high in cycles 1-12.

Optional Feature:
- Macro: ICACHE_CRITICAL_WORD_FIRST_EN.
- Defined:
  - at miss, latch start = miss_address[3:1];
  - requests go to base + 2*((start+issue_cnt) mod 8);
  - array_word_sel = (start+recv_cnt) mod 8;
  - crit_word_valid=1 for the first returned word only.
- Undefined:
  - start = 0 (linear order as above);
  - crit_word_valid=1 on the valid whose array_word_sel equals miss_address[3:1], using the latched miss offset.

Decomposition:
- Shared package icache_pkg:
  - WORDS_PER_BLOCK;
  - BLOCK_OFFSET_W (4 byte bits);
  - WORD_SEL_W (3);
  - the fill state enum (IDLE, FILL).
- Sub-module fill_counter: 3-bit counter with clear, enable and a done flag. Instantiated twice, for issue_cnt and recv_cnt.

Test Plan:
- Miss at 0x1236, memory latency 4, feature off -> requests to 0x1230..0x123E in cycles 1-8; writes word_sel 0..7 in cycles 5-12; write_tag_array in cycle 12; fsm_busy low from cycle 13; crit_word_valid on word_sel 3 only.
- Same miss with ICACHE_CRITICAL_WORD_FIRST_EN -> request order 0x1236, 0x1238, 0x123A, 0x123C, 0x123E, 0x1230, 0x1232, 0x1234; word_sel order 3,4,5,6,7,0,1,2; crit_word_valid in cycle 5.
- Valids with random gaps (0-3 idle cycles between valids) -> exactly 8 writes; tag pulse coincides with the 8th valid; fsm_busy holds high throughout.
- Second miss at 0x4000 asserted during a fill, plus a stray memory_data_valid in IDLE -> second miss ignored; base stays the first block; no write occurs in IDLE.
- rst pulsed at cycle 7 of a fill -> next cycle: IDLE, all outputs 0, no tag write; a following miss at 0x0010 runs a clean full fill.
- Back-to-back misses, the second asserted the cycle after fsm_busy falls -> second fill starts normally with counters cleared.
